// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample debounce FSM, press/release pulses.
// Optional long-press detector is built only when LONG_PRESS_EN is defined.
//
// state       | meaning
// LOW_STABLE  | debounced level 0, input agrees
// LOW_TO_HIGH | level 0, counting consecutive high samples
// HIGH_STABLE | debounced level 1, input agrees
// HIGH_TO_LOW | level 1, counting consecutive low samples
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic button_db,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    LOW_STABLE,
    LOW_TO_HIGH,
    HIGH_STABLE,
    HIGH_TO_LOW
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          btn_s;

  assign btn_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (btn_s) begin
          state_d = LOW_TO_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      LOW_TO_HIGH: begin
        if (!btn_s) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          db_d    = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!btn_s) begin
          state_d = HIGH_TO_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH_TO_LOW: begin
        if (btn_s) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          db_d    = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign button_db     = db_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Restart on every entry to HIGH_STABLE; saturate so one pulse per hold.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == HIGH_STABLE && state_q != HIGH_STABLE) begin
      hold_d = '0;
    end else if (state_q == HIGH_STABLE && state_d == HIGH_STABLE && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == HOLD_MAX - HOLD_ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomised + directed bench for button_debounce; per-cycle scoreboard against a
// run-length reference model (a level flips once the last D samples all disagree with it).
module tb_button_debounce;

  localparam int D = 4;
  localparam int H = 8;
`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic button;
  logic button_db, press, release_pulse, long_press;

  button_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button       (button),
    .button_db    (button_db),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic db;
    logic p;
    logic r;
    logic l;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int   last_press_edge = -1, last_rel_edge = -1, last_long_edge = -1;
  int   k_last = 0;

  // Reference model: samples reach the debouncer after two register stages.
  bit   s1 = 0, s2 = 0, mdb = 0;
  int   hold = 0;
  bit   hist[$];

  always @(posedge clk) begin
    exp_t e;
    bit   samp, prev, acc, db_old;
    edge_n++;
    e = '0;
    if (!reset_n) begin
      s1 = 0; s2 = 0; mdb = 0; hold = 0;
      hist.delete();
    end else begin
      samp = s2;
      s2   = s1;
      s1   = button;
      prev = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
      hist.push_back(samp);
      if (hist.size() > D) void'(hist.pop_front());
      db_old = mdb;
      acc = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == mdb) acc = 1'b0;
      if (acc) begin
        mdb = !mdb;
        if (mdb) e.p = 1'b1; else e.r = 1'b1;
        hold = 0;
      end else if (db_old) begin
        if (samp && prev) begin
          if (hold < H) begin
            hold++;
            if (hold == H) e.l = LP;
          end
        end else begin
          hold = 0;
        end
      end
      e.db = mdb;
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, got;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {button_db, press, release_pulse, long_press};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard edge %0d db/press/rel/long got=%b expected=%b", edge_n, got, e);
      end
      if (press)         begin press_cnt++; last_press_edge = edge_n; end
      if (release_pulse) begin rel_cnt++;   last_rel_edge   = edge_n; end
      if (long_press)    begin long_cnt++;  last_long_edge  = edge_n; end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Set button once, then let it stand for n falling edges; k_last = first edge sampling it.
  task automatic step(input logic b, input int n);
    @(negedge clk);
    #2 button = b;
    k_last = edge_n + 1;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int p0, r0, l0;
    reset_n = 1'b0;
    button  = 1'b1;

    // Held through reset: counts as a new press once reset lifts.
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b1;
    k_last = edge_n + 1;
    p0 = press_cnt; l0 = long_cnt;
    repeat (24) @(negedge clk);
    chk("press_after_reset_edge", last_press_edge, k_last + 5);
    chk("press_after_reset_cnt", press_cnt - p0, 1);
    chk("long_cnt_hold", long_cnt - l0, LP ? 1 : 0);
    if (LP) chk("long_edge", last_long_edge, k_last + 5 + H);

    // Release
    p0 = press_cnt; r0 = rel_cnt;
    step(1'b0, 12);
    chk("release_edge", last_rel_edge, k_last + 5);
    chk("release_cnt", rel_cnt - r0, 1);
    chk("release_no_press", press_cnt - p0, 0);

    // Clean press then release
    p0 = press_cnt;
    step(1'b1, 12);
    chk("clean_press_edge", last_press_edge, k_last + 5);
    chk("clean_press_cnt", press_cnt - p0, 1);
    step(1'b0, 12);

    // Bounce then hold
    p0 = press_cnt; r0 = rel_cnt;
    step(1'b1, 1); step(1'b0, 1); step(1'b1, 1); step(1'b0, 1);
    step(1'b1, 12);
    chk("bounce_press_edge", last_press_edge, k_last + 5);
    chk("bounce_press_cnt", press_cnt - p0, 1);
    chk("bounce_no_release", rel_cnt - r0, 0);
    step(1'b0, 12);

    // 3-cycle glitch from idle
    p0 = press_cnt; r0 = rel_cnt;
    step(1'b1, 3);
    step(1'b0, 12);
    chk("glitch_press_cnt", press_cnt - p0, 0);
    chk("glitch_release_cnt", rel_cnt - r0, 0);

    // Alternating input never settles
    p0 = press_cnt;
    for (int i = 0; i < 30; i++) step(i[0] ? 1'b0 : 1'b1, 1);
    step(1'b0, 10);
    chk("alternate_press_cnt", press_cnt - p0, 0);

    // Reset mid-debounce discards the partial count
    step(1'b1, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    k_last = edge_n + 1;
    repeat (12) @(negedge clk);
    chk("press_after_mid_reset", last_press_edge, k_last + 5);
    step(1'b0, 12);

    // Random runs with occasional resets
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 reset_n = 1'b1;
      end
      step(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end

    step(1'b0, 12);
    if (!LP) chk("long_never", long_cnt, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
